// File: rtl/player_controller_if.sv
// Player controller bus: frame/press/hit/scan inputs and sprite outputs.
interface player_controller_if;
    logic        startOfFrame;
    logic        leftPress;
    logic        rightPress;
    logic        hit;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        InsideRectangle;
    logic        visible;
    logic [10:0] topLeftX;
    logic [1:0]  lives;
    logic        gameOver;

    // Stimulus side: drives frame, press, hit and scan pixel; observes sprite state.
    modport master (
        output startOfFrame, leftPress, rightPress, hit, pixelX, pixelY,
        input  offsetX, offsetY, InsideRectangle, visible, topLeftX, lives, gameOver
    );

    // Controller side.
    modport slave (
        input  startOfFrame, leftPress, rightPress, hit, pixelX, pixelY,
        output offsetX, offsetY, InsideRectangle, visible, topLeftX, lives, gameOver
    );
endinterface

// File: rtl/player_controller.sv
// Player sprite controller: frame-synchronous movement, lives/blink FSM, box test.
module player_controller #(
    parameter int unsigned OBJECT_WIDTH_X  = 26,
    parameter int unsigned OBJECT_HEIGHT_Y = 37,
    parameter int unsigned START_X         = 307,
    parameter int unsigned TOP_Y           = 400,
    parameter int unsigned SPEED           = 4,
    parameter int unsigned RIGHT_LIMIT     = 614,
    parameter int unsigned START_LIVES     = 3,
    parameter int unsigned BLINK_FRAMES    = 120,
    parameter int unsigned BLINK_HALF      = 8
) (
    input  logic                clk,
    input  logic                reset,
    player_controller_if.slave  bus
);
    localparam int unsigned XW      = 11;
    localparam int unsigned CW      = 12;
    localparam int unsigned BLINK_W = $clog2(BLINK_FRAMES + 1);
    localparam int unsigned HALF_SH = $clog2(BLINK_HALF);

    typedef enum logic [1:0] {ALIVE, HIT_BLINK, DEAD} state_t;

    state_t              state_q, state_d;
    logic [XW-1:0]       top_left_x_q, top_left_x_d;
    logic [1:0]          lives_q, lives_d;
    logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic                game_over_q, game_over_d;
    logic                visible_q, visible_d;
    logic                inside_q, inside_d;
    logic [XW-1:0]       offset_x_q, offset_x_d;
    logic [XW-1:0]       offset_y_q, offset_y_d;

    logic [CW-1:0]       sum_right;
    logic [BLINK_W-1:0]  blink_phase;
    logic                in_x, in_y;

    // Next-state: movement, lives/blink FSM, visibility and registered box test.
    always_comb begin
        state_d      = state_q;
        top_left_x_d = top_left_x_q;
        lives_d      = lives_q;
        blink_cnt_d  = blink_cnt_q;
        game_over_d  = game_over_q;
        visible_d    = visible_q;
        inside_d     = 1'b0;
        offset_x_d   = '0;
        offset_y_d   = '0;
        sum_right    = CW'(top_left_x_q) + CW'(SPEED);
        blink_phase  = '0;

        // Position only moves on the frame pulse, and never once dead.
        if (bus.startOfFrame && (state_q != DEAD)) begin
            if (bus.leftPress && !bus.rightPress) begin
                top_left_x_d = (top_left_x_q >= XW'(SPEED)) ? (top_left_x_q - XW'(SPEED)) : '0;
            end else if (bus.rightPress && !bus.leftPress) begin
                top_left_x_d = (sum_right > CW'(RIGHT_LIMIT)) ? XW'(RIGHT_LIMIT) : sum_right[XW-1:0];
            end
        end

        case (state_q)
            ALIVE: begin
                // A coincident frame pulse does not count down the freshly loaded blink.
                if (bus.hit) begin
                    if (lives_q > 2'd1) begin
                        lives_d     = lives_q - 2'd1;
                        blink_cnt_d = BLINK_W'(BLINK_FRAMES);
                        state_d     = HIT_BLINK;
                    end else begin
                        lives_d     = 2'd0;
                        game_over_d = 1'b1;
                        state_d     = DEAD;
                    end
                end
            end
            HIT_BLINK: begin
                if (bus.startOfFrame) begin
                    if (blink_cnt_q <= BLINK_W'(1)) begin
                        blink_cnt_d = '0;
                        state_d     = ALIVE;
                    end else begin
                        blink_cnt_d = blink_cnt_q - BLINK_W'(1);
                    end
                end
            end
            DEAD: begin
                state_d = DEAD;
            end
            default: begin
                state_d = ALIVE;
            end
        endcase

        // Odd blink half-periods (counted from the top) hide the sprite.
        blink_phase = blink_cnt_d >> HALF_SH;
        case (state_d)
            ALIVE:     visible_d = 1'b1;
            HIT_BLINK: visible_d = ~blink_phase[0];
            default:   visible_d = 1'b0;
        endcase

        in_x = (CW'(bus.pixelX) >= CW'(top_left_x_q)) &&
               (CW'(bus.pixelX) <  (CW'(top_left_x_q) + CW'(OBJECT_WIDTH_X)));
        in_y = (CW'(bus.pixelY) >= CW'(TOP_Y)) &&
               (CW'(bus.pixelY) <  (CW'(TOP_Y) + CW'(OBJECT_HEIGHT_Y)));
        inside_d = in_x && in_y;
        if (inside_d) begin
            offset_x_d = bus.pixelX - top_left_x_q;
            offset_y_d = bus.pixelY - XW'(TOP_Y);
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ALIVE;
            top_left_x_q <= XW'(START_X);
            lives_q      <= 2'(START_LIVES);
            blink_cnt_q  <= '0;
            game_over_q  <= 1'b0;
            visible_q    <= 1'b1;
            inside_q     <= 1'b0;
            offset_x_q   <= '0;
            offset_y_q   <= '0;
        end else begin
            state_q      <= state_d;
            top_left_x_q <= top_left_x_d;
            lives_q      <= lives_d;
            blink_cnt_q  <= blink_cnt_d;
            game_over_q  <= game_over_d;
            visible_q    <= visible_d;
            inside_q     <= inside_d;
            offset_x_q   <= offset_x_d;
            offset_y_q   <= offset_y_d;
        end
    end

    assign bus.topLeftX        = top_left_x_q;
    assign bus.lives           = lives_q;
    assign bus.gameOver        = game_over_q;
    assign bus.visible         = visible_q;
    assign bus.InsideRectangle = inside_q;
    assign bus.offsetX         = offset_x_q;
    assign bus.offsetY         = offset_y_q;
endmodule

// File: tb/tb_player_controller.sv
// Directed bench for player_controller: movement limits, box test, lives/blink FSM, reset.
module tb_player_controller;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    player_controller_if bus ();

    player_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply n frame pulses with the given press levels; returns on a falling edge.
    task automatic frames(input logic l, input logic r, input int n);
        repeat (n) begin
            @(negedge clk);
            bus.startOfFrame = 1'b1;
            bus.leftPress    = l;
            bus.rightPress   = r;
            @(negedge clk);
            bus.startOfFrame = 1'b0;
        end
        bus.leftPress  = 1'b0;
        bus.rightPress = 1'b0;
    endtask

    task automatic hit_pulse();
        @(negedge clk);
        bus.hit = 1'b1;
        @(negedge clk);
        bus.hit = 1'b0;
    endtask

    task automatic pixel(input int x, input int y);
        @(negedge clk);
        bus.pixelX = 11'(x);
        bus.pixelY = 11'(y);
        @(negedge clk);
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        reset            = 1'b1;
        bus.startOfFrame = 1'b0;
        bus.leftPress    = 1'b0;
        bus.rightPress   = 1'b0;
        bus.hit          = 1'b0;
        bus.pixelX       = '0;
        bus.pixelY       = '0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_x", 32'(bus.topLeftX), 307);
        chk("rst_lives", 32'(bus.lives), 3);
        chk("rst_gameover", 32'(bus.gameOver), 0);
        chk("rst_visible", 32'(bus.visible), 1);
        chk("rst_inside", 32'(bus.InsideRectangle), 0);
        chk("rst_offx", 32'(bus.offsetX), 0);
        @(negedge clk);
        reset = 1'b0;

        // Box test and offsets, including edges
        pixel(310, 405);
        chk("box_in", 32'(bus.InsideRectangle), 1);
        chk("box_offx", 32'(bus.offsetX), 3);
        chk("box_offy", 32'(bus.offsetY), 5);
        pixel(333, 405);
        chk("box_right_edge", 32'(bus.InsideRectangle), 0);
        chk("box_out_offx", 32'(bus.offsetX), 0);
        chk("box_out_offy", 32'(bus.offsetY), 0);
        pixel(332, 436);
        chk("box_corner", 32'(bus.InsideRectangle), 1);
        chk("box_corner_offx", 32'(bus.offsetX), 25);
        chk("box_corner_offy", 32'(bus.offsetY), 36);
        pixel(307, 399);
        chk("box_above", 32'(bus.InsideRectangle), 0);
        pixel(306, 410);
        chk("box_left", 32'(bus.InsideRectangle), 0);
        bus.pixelX = '0;
        bus.pixelY = '0;

        // No movement without a frame pulse
        @(negedge clk);
        bus.leftPress = 1'b1;
        repeat (4) @(negedge clk);
        bus.leftPress = 1'b0;
        chk("no_tear", 32'(bus.topLeftX), 307);

        // Single moves and holds
        frames(1'b0, 1'b1, 1);
        chk("right_once", 32'(bus.topLeftX), 311);
        frames(1'b1, 1'b1, 1);
        chk("both_hold", 32'(bus.topLeftX), 311);
        frames(1'b0, 1'b0, 1);
        chk("none_hold", 32'(bus.topLeftX), 311);

        // Saturation at the right limit, then walk left to 2 and clamp at 0
        frames(1'b0, 1'b1, 200);
        chk("right_sat", 32'(bus.topLeftX), 614);
        frames(1'b1, 1'b0, 153);
        chk("left_to_2", 32'(bus.topLeftX), 2);
        frames(1'b1, 1'b0, 1);
        chk("left_clamp", 32'(bus.topLeftX), 0);
        frames(1'b1, 1'b0, 46);
        chk("left_no_wrap", 32'(bus.topLeftX), 0);

        // First hit: blink starts hidden (count 120), phase tracks count/8
        hit_pulse();
        chk("hit1_lives", 32'(bus.lives), 2);
        chk("hit1_vis_120", 32'(bus.visible), 0);
        frames(1'b0, 1'b0, 1);
        chk("blink_vis_119", 32'(bus.visible), 1);
        frames(1'b0, 1'b0, 7);
        chk("blink_vis_112", 32'(bus.visible), 1);
        frames(1'b0, 1'b0, 1);
        chk("blink_vis_111", 32'(bus.visible), 0);
        hit_pulse();
        chk("blink_hit_ignored", 32'(bus.lives), 2);
        frames(1'b0, 1'b0, 110);
        hit_pulse();
        chk("blink_frame119_ignored", 32'(bus.lives), 2);
        frames(1'b0, 1'b0, 1);
        chk("blink_end_vis", 32'(bus.visible), 1);

        // Hit coincident with frame pulse and right press
        @(negedge clk);
        bus.hit          = 1'b1;
        bus.startOfFrame = 1'b1;
        bus.rightPress   = 1'b1;
        @(negedge clk);
        bus.hit          = 1'b0;
        bus.startOfFrame = 1'b0;
        bus.rightPress   = 1'b0;
        chk("coinc_lives", 32'(bus.lives), 1);
        chk("coinc_x", 32'(bus.topLeftX), 4);
        chk("coinc_vis_120", 32'(bus.visible), 0);
        frames(1'b0, 1'b0, 120);
        chk("blink2_end_vis", 32'(bus.visible), 1);

        // Last hit: dead, frozen, further hits ignored
        hit_pulse();
        chk("dead_lives", 32'(bus.lives), 0);
        chk("dead_gameover", 32'(bus.gameOver), 1);
        chk("dead_visible", 32'(bus.visible), 0);
        frames(1'b0, 1'b1, 5);
        chk("dead_frozen", 32'(bus.topLeftX), 4);
        hit_pulse();
        chk("dead_hit_ignored", 32'(bus.lives), 0);

        // Asynchronous reset out of DEAD, then resume
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("areset_lives", 32'(bus.lives), 3);
        chk("areset_x", 32'(bus.topLeftX), 307);
        chk("areset_gameover", 32'(bus.gameOver), 0);
        chk("areset_visible", 32'(bus.visible), 1);
        @(negedge clk);
        reset = 1'b0;
        frames(1'b0, 1'b1, 1);
        chk("resume_x", 32'(bus.topLeftX), 311);
        hit_pulse();
        chk("resume_hit", 32'(bus.lives), 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
